sram_ctrl: RTL
==============

# sram_ctrl

Clocked, parametrised controller for asynchronous single-port SRAM. It accepts one read or write request at a time over a ready/req handshake and sequences chip-enable, output-enable, write-enable, address and the bidirectional data bus with programmable cycle counts. It sits between the UART command logic and the external SRAM pins. It replaces the delay-based combinational controller with a synthesizable FSM.

## Interface
- DATA_W, 16, data bus width
- ADDR_W, 18, address width
- SETUP_CYC, 1, write address/data setup cycles before ram_we_n falls (min 1)
- WE_CYC, 2, ram_we_n low cycles (min 1)
- HOLD_CYC, 1, data hold cycles after ram_we_n rises (min 1)
- RD_CYC, 2, ram_oe_n low cycles before rdata is sampled (min 1)
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req  in  1  request strobe; sampled only while ready=1
- wr  in  1  1=write, 0=read; sampled with req
- addr_in  in  ADDR_W  request address
- wdata  in  DATA_W  write data
- ready  out  1  controller idle, can accept req
- done  out  1  one-cycle completion pulse
- rdata  out  DATA_W  last read data; held until next read completes
- err  out  1  sticky write-verify mismatch flag
- ram_ce_n, ram_oe_n, ram_we_n  out  1 each  SRAM strobes, active low
- ram_addr  out  ADDR_W  SRAM address, registered
- ram_data  inout  DATA_W  SRAM data; driven only in write states, else Z

## Operation
- States: IDLE, WR_SETUP, WR_PULSE, WR_HOLD, RD_WAIT, VERIFY (macro only). One down-counter, width sized for the largest *_CYC.
- IDLE: ready=1, all strobes high, bus Z. On req=1, capture wr/addr_in/wdata into registers. Then go to WR_SETUP or RD_WAIT.
- WR_SETUP: SETUP_CYC cycles. ce_n=0, addr and data driven, we_n=1.
- WR_PULSE: WE_CYC cycles. we_n=0.
- WR_HOLD: HOLD_CYC cycles. we_n=1, data still driven. Then go to IDLE and pulse done.
- RD_WAIT: RD_CYC cycles. ce_n=0, oe_n=0, bus Z. Latch ram_data into rdata on the last cycle, return to IDLE and pulse done.
- Data is driven only in WR_* states, where oe_n=1. ram_oe_n=0 and an active data driver never coexist.
- req while ready=0 is ignored, with no queueing. Input changes after acceptance have no effect.
- Reset values: ready=1, done=0, rdata=0, err=0, ram_ce_n=ram_oe_n=ram_we_n=1, ram_addr=0, bus Z, state IDLE.
- Reset asserted mid-transaction forces the reset values immediately, even if ram_we_n is low. The write is then undefined and no done is issued.
- A *_CYC parameter set to 0 is treated as 1.

## Timing
- Request accepted at edge k means the first active state begins at cycle k+1.
- Write: done=1 during cycle k+SETUP_CYC+WE_CYC+HOLD_CYC+1. With defaults, done is in cycle k+5.
- Read: done=1 and rdata valid during cycle k+RD_CYC+1. rdata stays stable until the next read's done.
- ready returns to 1 in the same cycle as done. A req in that cycle is accepted, so back-to-back transactions have no idle gap.
- Strobe and address outputs are registered, so they are glitch-free.

## Configuration
- SRAM_CTRL_VERIFY_EN defined: after WR_HOLD, the FSM enters VERIFY for RD_CYC cycles (oe_n=0, bus Z, same address).
  - It compares ram_data with the captured wdata. On mismatch, err is set and stays 1 until rst_n.
  - done is delayed by RD_CYC cycles. rdata is not updated.
- Not defined: no VERIFY state, err is tied to 0, and write latency is as given under Timing.

## Test plan
- Reset: hold rst_n=0 for 3 cycles -> ready=1, strobes all 1, ram_data=Z, done=0, err=0.
- Write with defaults, req at edge k, addr 0x00012, data 0xA5C3:
  - ram_we_n=0 exactly in cycles k+2..k+3 with bus=0xA5C3.
  - done pulse in cycle k+5.
- Read of 0x00012 from the SRAM model -> oe_n=0 for 2 cycles, rdata=0xA5C3 with done in cycle k+3, bus never driven.
- Back-to-back: write 0x0001F=0x1234, then read 0x0001F issued in the done cycle -> read accepted with no gap, rdata=0x1234.
- rst_n pulled low during WR_PULSE -> ram_we_n=1 and bus Z in the same cycle, no done, ready=1 after release.
- With SRAM_CTRL_VERIFY_EN, write 0xFFFF to a model bit stuck at 0 on bit 3 -> err=1 after done, stays 1 through a further correct write.

Source files
------------

// File: rtl/sram_ctrl.sv
// sram_ctrl -- clocked controller for an asynchronous single-port SRAM.
//
// Accepts one read or write request at a time over a ready/req handshake.
// It then sequences chip-enable, output-enable, write-enable, address and
// the bidirectional data bus. The number of cycles in each phase is set by
// parameters.
//
// Optional feature: define SRAM_CTRL_VERIFY_EN to add a read-back VERIFY
// phase after every write. A mismatch sets the sticky err flag. Without the
// macro, err is tied low and there is no VERIFY phase.
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   req       request strobe, sampled only while ready=1
//   wr        1=write, 0=read, sampled with req
//   addr_in   request address
//   wdata     write data
//   ready     controller idle, can accept req
//   done      one-cycle completion pulse
//   rdata     last read data, held until the next read completes
//   err       sticky write-verify mismatch flag
//   ram_ce_n  SRAM chip enable, active low, registered
//   ram_oe_n  SRAM output enable, active low, registered
//   ram_we_n  SRAM write enable, active low, registered
//   ram_addr  SRAM address, registered
//   ram_data  SRAM data bus; driven only in write states, otherwise Z
module sram_ctrl #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 18,
    parameter int SETUP_CYC = 1,
    parameter int WE_CYC    = 2,
    parameter int HOLD_CYC  = 1,
    parameter int RD_CYC    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] wdata,
    output logic              ready,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic              ram_ce_n,
    output logic              ram_oe_n,
    output logic              ram_we_n,
    output logic [ADDR_W-1:0] ram_addr,
    inout  wire  [DATA_W-1:0] ram_data
);

    // A cycle count of zero is treated as one.
    localparam int S_N   = (SETUP_CYC < 1) ? 1 : SETUP_CYC;
    localparam int W_N   = (WE_CYC    < 1) ? 1 : WE_CYC;
    localparam int H_N   = (HOLD_CYC  < 1) ? 1 : HOLD_CYC;
    localparam int R_N   = (RD_CYC    < 1) ? 1 : RD_CYC;
    localparam int MAX_A = (S_N > W_N) ? S_N : W_N;
    localparam int MAX_B = (H_N > R_N) ? H_N : R_N;
    localparam int MAX_N = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    // The counter holds values from 0 to MAX_N-1.
    localparam int CNT_W = (MAX_N < 2) ? 1 : $clog2(MAX_N);

    localparam logic [CNT_W-1:0] S_LD = CNT_W'(S_N - 1);
    localparam logic [CNT_W-1:0] W_LD = CNT_W'(W_N - 1);
    localparam logic [CNT_W-1:0] H_LD = CNT_W'(H_N - 1);
    localparam logic [CNT_W-1:0] R_LD = CNT_W'(R_N - 1);

    // VERIFY is reachable only when the verify feature is built in.
    typedef enum logic [2:0] {
        IDLE, WR_SETUP, WR_PULSE, WR_HOLD, RD_WAIT, VERIFY
    } state_t;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              done_reg, done_next;
    logic              capture, rd_latch;
    logic [DATA_W-1:0] rdata_reg, wdata_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic              ce_n_reg, oe_n_reg, we_n_reg, drive_reg;
`ifdef SRAM_CTRL_VERIFY_EN
    logic              err_reg, err_set;
`endif

    // Next-state logic. The counter is loaded with (cycles-1) on entry to a
    // timed state. The state is left when the counter reaches zero.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        done_next  = 1'b0;
        capture    = 1'b0;
        rd_latch   = 1'b0;
`ifdef SRAM_CTRL_VERIFY_EN
        err_set    = 1'b0;
`endif
        case (state_reg)
            IDLE: begin
                if (req) begin
                    capture = 1'b1;
                    if (wr) begin
                        state_next = WR_SETUP;
                        cnt_next   = S_LD;
                    end else begin
                        state_next = RD_WAIT;
                        cnt_next   = R_LD;
                    end
                end
            end
            WR_SETUP: begin
                if (cnt_reg == '0) begin
                    state_next = WR_PULSE;
                    cnt_next   = W_LD;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            WR_PULSE: begin
                if (cnt_reg == '0) begin
                    state_next = WR_HOLD;
                    cnt_next   = H_LD;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            WR_HOLD: begin
                if (cnt_reg == '0) begin
`ifdef SRAM_CTRL_VERIFY_EN
                    state_next = VERIFY;
                    cnt_next   = R_LD;
`else
                    state_next = IDLE;
                    done_next  = 1'b1;
`endif
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            RD_WAIT: begin
                if (cnt_reg == '0) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                    rd_latch   = 1'b1;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
`ifdef SRAM_CTRL_VERIFY_EN
            VERIFY: begin
                if (cnt_reg == '0) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                    err_set    = (ram_data != wdata_reg);
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
`endif
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The strobes and the bus enable are registered from state_next. This
    // keeps them aligned with the state register and free of glitches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            done_reg  <= 1'b0;
            rdata_reg <= '0;
            wdata_reg <= '0;
            addr_reg  <= '0;
            ce_n_reg  <= 1'b1;
            oe_n_reg  <= 1'b1;
            we_n_reg  <= 1'b1;
            drive_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            done_reg  <= done_next;
            if (capture) begin
                addr_reg  <= addr_in;
                wdata_reg <= wdata;
            end
            if (rd_latch) begin
                rdata_reg <= ram_data;
            end
            ce_n_reg  <= (state_next == IDLE);
            oe_n_reg  <= !((state_next == RD_WAIT) || (state_next == VERIFY));
            we_n_reg  <= (state_next != WR_PULSE);
            drive_reg <= (state_next == WR_SETUP) || (state_next == WR_PULSE) ||
                         (state_next == WR_HOLD);
        end
    end

`ifdef SRAM_CTRL_VERIFY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_reg <= 1'b0;
        end else if (err_set) begin
            err_reg <= 1'b1;
        end
    end
    assign err = err_reg;
`else
    assign err = 1'b0;
`endif

    assign ready    = (state_reg == IDLE);
    assign done     = done_reg;
    assign rdata    = rdata_reg;
    assign ram_ce_n = ce_n_reg;
    assign ram_oe_n = oe_n_reg;
    assign ram_we_n = we_n_reg;
    assign ram_addr = addr_reg;
    assign ram_data = drive_reg ? wdata_reg : {DATA_W{1'bz}};

endmodule
